ram_port_ctrl: RTL and testbench

Sequencer that sits directly upstream of the single-port synchronous 16x8 RAM and owns its shared bidirectional data bus. It turns a valid/ready request stream into correctly timed `we`/`re`/`addr` strobes, drives the write data onto the tri-state bus, and captures read data with a registered response pulse. It also provides a whole-array clear sweep that writes a fill value to every address.

---
 rtl/ram_port_ctrl_pkg.sv | 16 +
 rtl/ram_port_ctrl_if.sv | 27 ++
 rtl/ram_port_ctrl.sv | 111 +++++++++++
 tb/tb_ram_port_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_port_ctrl_pkg.sv
// Shared types and default sizing for the RAM port sequencer.
package ram_port_ctrl_pkg;

    localparam int WIDTH_DEF    = 8;
    localparam int DEPTH_DEF    = 16;
    localparam int ADDR_BUS_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR   = 3'd1,
        ST_RD1  = 3'd2,
        ST_RD2  = 3'd3,
        ST_CLR  = 3'd4
    } state_t;

endpackage

// File: rtl/ram_port_ctrl_if.sv
// Request/response/clear handshake bundle between a client and ram_port_ctrl.
interface ram_port_ctrl_if #(
    parameter int WIDTH    = 8,
    parameter int ADDR_BUS = 4
);
    logic                req_valid;
    logic                req_ready;
    logic                req_wr;
    logic [ADDR_BUS-1:0] req_addr;
    logic [WIDTH-1:0]    req_wdata;
    logic                clr_start;
    logic [WIDTH-1:0]    clr_fill;
    logic                busy;
    logic                clr_done;
    logic                rsp_valid;
    logic [WIDTH-1:0]    rsp_data;

    modport master (
        output req_valid, req_wr, req_addr, req_wdata, clr_start, clr_fill,
        input  req_ready, busy, clr_done, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata, clr_start, clr_fill,
        output req_ready, busy, clr_done, rsp_valid, rsp_data
    );
endinterface

// File: rtl/ram_port_ctrl.sv
// Sequencer for a single-port synchronous RAM: request FSM, clear sweep and
// ownership of the shared tri-state data bus.
module ram_port_ctrl
    import ram_port_ctrl_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int ADDR_BUS = ADDR_BUS_DEF
) (
    input  logic                clk,
    input  logic                rst,
    ram_port_ctrl_if.slave      bus,
    output logic                ram_we,
    output logic                ram_re,
    output logic [ADDR_BUS-1:0] ram_addr,
    inout  wire  [WIDTH-1:0]    ram_data
);

    state_t              state_r, next_s;
    logic [ADDR_BUS-1:0] cnt_r, cnt_next_s;
    logic [ADDR_BUS-1:0] addr_r, addr_next_s;
    logic [WIDTH-1:0]    data_r, data_next_s;
    logic [WIDTH-1:0]    rsp_data_r;
    logic                we_r, re_r, we_next_s, re_next_s;
    logic                rsp_valid_r, clr_done_r, done_next_s, busy_r;

    // Next-state, address/data latch and clear-counter decode.
    always_comb begin
        next_s      = state_r;
        cnt_next_s  = cnt_r;
        addr_next_s = addr_r;
        data_next_s = data_r;
        done_next_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.clr_start) begin
                    next_s      = ST_CLR;
                    cnt_next_s  = {ADDR_BUS{1'b0}};
                    addr_next_s = {ADDR_BUS{1'b0}};
                    data_next_s = bus.clr_fill;
                end else if (bus.req_valid) begin
                    next_s      = bus.req_wr ? ST_WR : ST_RD1;
                    addr_next_s = bus.req_addr;
                    data_next_s = bus.req_wdata;
                end else begin
                    next_s = ST_IDLE;
                end
            end
            ST_WR:  next_s = ST_IDLE;
            ST_RD1: next_s = ST_RD2;
            ST_RD2: next_s = ST_IDLE;
            ST_CLR: begin
                if (cnt_r == ADDR_BUS'(DEPTH - 1)) begin
                    next_s      = ST_IDLE;
                    cnt_next_s  = {ADDR_BUS{1'b0}};
                    done_next_s = 1'b1;
                end else begin
                    cnt_next_s  = cnt_r + ADDR_BUS'(1);
                    addr_next_s = cnt_r + ADDR_BUS'(1);
                end
            end
            default: next_s = ST_IDLE;
        endcase
        // Strobes are registered from the state being entered so they line up with it.
        we_next_s = (next_s == ST_WR) || (next_s == ST_CLR);
        re_next_s = (next_s == ST_RD1) || (next_s == ST_RD2);
    end

    // State, strobe, latch and response registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {ADDR_BUS{1'b0}};
            addr_r      <= {ADDR_BUS{1'b0}};
            data_r      <= {WIDTH{1'b0}};
            we_r        <= 1'b0;
            re_r        <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= {WIDTH{1'b0}};
            clr_done_r  <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= next_s;
            cnt_r       <= cnt_next_s;
            addr_r      <= addr_next_s;
            data_r      <= data_next_s;
            we_r        <= we_next_s;
            re_r        <= re_next_s;
            clr_done_r  <= done_next_s;
            busy_r      <= (next_s != ST_IDLE);
            rsp_valid_r <= (state_r == ST_RD2);
            if (state_r == ST_RD2) begin
                rsp_data_r <= ram_data;
            end else begin
                rsp_data_r <= rsp_data_r;
            end
        end
    end

    assign ram_we        = we_r;
    assign ram_re        = re_r;
    assign ram_addr      = addr_r;
    assign ram_data      = we_r ? data_r : {WIDTH{1'bz}};

    assign bus.req_ready = rst && (state_r == ST_IDLE) && !bus.clr_start;
    assign bus.busy      = busy_r;
    assign bus.clr_done  = clr_done_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_data  = rsp_data_r;

endmodule

// File: tb/tb_ram_port_ctrl.sv
// Randomized bench for ram_port_ctrl paired with a behavioural 16x8 sync RAM,
// checked every cycle against a transaction-level model.
module tb_ram_port_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ram_srst = 1'b1;
    logic       ram_we, ram_re;
    logic [3:0] ram_addr;
    wire  [7:0] ram_data;

    int checks = 0;
    int failures = 0;

    ram_port_ctrl_if #(.WIDTH(8), .ADDR_BUS(4)) bus ();

    ram_port_ctrl #(.WIDTH(8), .DEPTH(16), .ADDR_BUS(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .ram_we   (ram_we),
        .ram_re   (ram_re),
        .ram_addr (ram_addr),
        .ram_data (ram_data)
    );

    always #5 clk = ~clk;

    // Single-port synchronous RAM with registered output, drives the bus on reads.
    logic [7:0] ram_mem [16];
    logic [7:0] ram_dout;
    always @(posedge clk) begin
        if (ram_srst) begin
            for (int i = 0; i < 16; i++) ram_mem[i] <= 8'h00;
            ram_dout <= 8'h00;
        end else begin
            if (ram_we) ram_mem[ram_addr] <= ram_data;
            if (ram_re) ram_dout <= ram_mem[ram_addr];
        end
    end
    assign ram_data = (ram_re && !ram_we) ? ram_dout : {8{1'bz}};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one operation in flight, aged by clock edges.
    typedef enum int {M_NONE, M_WR, M_RD, M_CLR} mkind_t;
    mkind_t     m_kind = M_NONE;
    int         m_age = 0;
    logic [3:0] m_addr = 4'h0;
    logic [7:0] m_data = 8'h00;
    logic [7:0] m_mem [16];
    logic       m_init = 1'b0;
    logic       exp_rsp_valid = 1'b0;
    logic [7:0] exp_rsp_data = 8'h00;
    logic       exp_done = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (!m_init) begin
                for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
                m_init = 1'b1;
            end
            m_kind = M_NONE;
            m_age = 0;
            exp_rsp_valid = 1'b0;
            exp_rsp_data = 8'h00;
            exp_done = 1'b0;
        end else begin
            chk("we_re_exclusive", {31'd0, ram_we && ram_re}, 32'd0);
            chk("rsp_valid", {31'd0, bus.rsp_valid}, {31'd0, exp_rsp_valid});
            chk("rsp_data", {24'd0, bus.rsp_data}, {24'd0, exp_rsp_data});
            chk("clr_done", {31'd0, bus.clr_done}, {31'd0, exp_done});
            chk("busy", {31'd0, bus.busy}, {31'd0, m_kind != M_NONE});
            chk("req_ready", {31'd0, bus.req_ready},
                {31'd0, (m_kind == M_NONE) && !bus.clr_start});
            chk("ram_we", {31'd0, ram_we}, {31'd0, (m_kind == M_WR) || (m_kind == M_CLR)});
            chk("ram_re", {31'd0, ram_re}, {31'd0, m_kind == M_RD});
            case (m_kind)
                M_WR: begin
                    chk("wr_addr", {28'd0, ram_addr}, {28'd0, m_addr});
                    chk("wr_data", {24'd0, ram_data}, {24'd0, m_data});
                end
                M_RD: begin
                    chk("rd_addr", {28'd0, ram_addr}, {28'd0, m_addr});
                    if (m_age == 1) chk("rd_bus_known", {31'd0, $isunknown(ram_data)}, 32'd0);
                end
                M_CLR: begin
                    chk("clr_addr", {28'd0, ram_addr}, m_age);
                    chk("clr_data", {24'd0, ram_data}, {24'd0, m_data});
                end
                default: ;
            endcase
            exp_rsp_valid = 1'b0;
            exp_done = 1'b0;
            case (m_kind)
                M_NONE: begin
                    if (bus.clr_start) begin
                        m_kind = M_CLR; m_age = 0; m_data = bus.clr_fill;
                    end else if (bus.req_valid) begin
                        m_addr = bus.req_addr;
                        m_age = 0;
                        if (bus.req_wr) begin
                            m_kind = M_WR; m_data = bus.req_wdata;
                        end else begin
                            m_kind = M_RD; m_data = m_mem[bus.req_addr];
                        end
                    end
                end
                M_WR: begin
                    m_mem[m_addr] = m_data;
                    m_kind = M_NONE;
                end
                M_RD: begin
                    if (m_age == 0) begin
                        m_age = 1;
                    end else begin
                        exp_rsp_valid = 1'b1;
                        exp_rsp_data = m_data;
                        m_kind = M_NONE;
                    end
                end
                M_CLR: begin
                    m_mem[m_age] = m_data;
                    if (m_age == 15) begin
                        m_kind = M_NONE; exp_done = 1'b1;
                    end else begin
                        m_age++;
                    end
                end
                default: m_kind = M_NONE;
            endcase
        end
    end

    // All driver tasks start and end at posedge + 2.
    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic do_req(input logic wr, input logic [3:0] a, input logic [7:0] d, output int n);
        bit acc = 1'b0;
        n = 0;
        bus.req_valid = 1'b1; bus.req_wr = wr; bus.req_addr = a; bus.req_wdata = d;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = bus.req_valid && bus.req_ready;
            tick();
            n++;
        end
        if (!acc) chk("accept_timeout", 32'd0, 32'd1);
        bus.req_valid = 1'b0;
    endtask

    task automatic read_expect(input logic [3:0] a, input logic [7:0] exp, input string name);
        int n, k;
        bit seen = 1'b0;
        logic [7:0] got = 8'h00;
        do_req(1'b0, a, 8'h00, n);
        k = 0;
        while (!seen && k < 10) begin
            @(negedge clk);
            k++;
            if (bus.rsp_valid) begin seen = 1'b1; got = bus.rsp_data; end
        end
        chk({name, "_latency"}, k - 1, 32'd2);
        chk(name, {24'd0, got}, {24'd0, exp});
        tick();
    endtask

    task automatic do_clear(input logic [7:0] fill, output int we_cnt);
        int k = 0;
        bit done = 1'b0;
        we_cnt = 0;
        bus.clr_start = 1'b1; bus.clr_fill = fill;
        tick();
        bus.clr_start = 1'b0;
        while (!done && k < 40) begin
            @(negedge clk);
            k++;
            if (ram_we) we_cnt++;
            if (bus.clr_done) done = 1'b1;
        end
        chk("clr_done_seen", {31'd0, done}, 32'd1);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, wc, cnt;
        bit acc;
        bus.req_valid = 1'b0; bus.req_wr = 1'b0; bus.req_addr = 4'h0;
        bus.req_wdata = 8'h00; bus.clr_start = 1'b0; bus.clr_fill = 8'h00;

        repeat (3) tick();
        chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_rsp_data", {24'd0, bus.rsp_data}, 32'd0);
        chk("rst_we_re", {30'd0, ram_we, ram_re}, 32'd0);
        chk("rst_addr", {28'd0, ram_addr}, 32'd0);
        ram_srst = 1'b0;
        rst = 1'b1;
        repeat (2) tick();

        // Single write then readback.
        do_req(1'b1, 4'd3, 8'hA5, n);
        tick();
        read_expect(4'd3, 8'hA5, "rd_a5");

        // Back-to-back writes with valid held, then read all.
        for (int i = 0; i < 16; i++) do_req(1'b1, 4'(i), 8'(i * 17), n);
        chk("wr_accept_spacing", n, 32'd2);
        tick();
        for (int i = 0; i < 16; i++) read_expect(4'(i), 8'(i * 17), "rd_sweep");

        // Full clear sweep.
        do_clear(8'h3C, wc);
        chk("clr_we_cycles", wc, 32'd16);
        read_expect(4'd15, 8'h3C, "rd_clr15");

        // Clear start beats a same-edge write request.
        bus.clr_start = 1'b1; bus.clr_fill = 8'h5A;
        bus.req_valid = 1'b1; bus.req_wr = 1'b1; bus.req_addr = 4'd5; bus.req_wdata = 8'hFF;
        @(negedge clk);
        chk("clr_prio_ready", {31'd0, bus.req_ready}, 32'd0);
        tick();
        bus.clr_start = 1'b0;
        do_req(1'b1, 4'd5, 8'hFF, n);
        chk("held_req_wait", n, 32'd17);
        tick();
        read_expect(4'd5, 8'hFF, "rd_held5");
        read_expect(4'd0, 8'h5A, "rd_fill0");

        // Randomized traffic.
        acc = 1'b0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            acc = bus.req_valid && bus.req_ready;
            tick();
            bus.clr_start = 1'b0;
            if (!bus.req_valid || acc) begin
                bus.req_valid = ($urandom_range(0, 3) != 0);
                bus.req_wr = 1'($urandom_range(0, 1));
                bus.req_addr = 4'($urandom_range(0, 15));
                bus.req_wdata = 8'($urandom_range(0, 255));
            end
            if (!bus.busy && $urandom_range(0, 59) == 0) begin
                bus.clr_start = 1'b1;
                bus.clr_fill = 8'($urandom_range(0, 255));
            end
        end
        bus.clr_start = 1'b0;
        bus.req_valid = 1'b0;
        repeat (20) tick();

        // Reset mid-clear leaves the lower addresses filled.
        do_clear(8'h11, wc);
        bus.clr_start = 1'b1; bus.clr_fill = 8'h99;
        tick();
        bus.clr_start = 1'b0;
        cnt = 0;
        while (ram_addr != 4'd7 && cnt < 30) begin tick(); cnt++; end
        chk("mid_clr_reached7", {28'd0, ram_addr}, 32'd7);
        rst = 1'b0;
        #1;
        chk("async_rst_we_re", {30'd0, ram_we, ram_re}, 32'd0);
        chk("async_rst_addr", {28'd0, ram_addr}, 32'd0);
        chk("async_rst_ready", {31'd0, bus.req_ready}, 32'd0);
        chk("async_rst_busy", {31'd0, bus.busy}, 32'd0);
        repeat (2) tick();
        rst = 1'b1;
        repeat (2) tick();
        read_expect(4'd0, 8'h99, "rst_keep0");
        read_expect(4'd6, 8'h99, "rst_keep6");
        read_expect(4'd7, 8'h11, "rst_old7");
        read_expect(4'd15, 8'h11, "rst_old15");
        repeat (4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
